// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the MSI snoopy-bus arbiter: default widths,
// bus message encodings and the arbiter FSM state type.
package snoop_bus_pkg;

    localparam int unsigned DEF_NUM_PROCS = 4;
    localparam int unsigned DEF_ADDR_SIZE = 2;
    localparam int unsigned DEF_MSG_W     = 2;
    localparam int unsigned DEF_TIMEOUT   = 15;

    // Bus message encodings
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_RD   = 2'd1;
    localparam logic [1:0] BUS_RDX  = 2'd2;
    localparam logic [1:0] BUS_UPGR = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } bus_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector. Search begins one past the last
// winner and wraps; before the first grant after reset it begins at 0.
module rr_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int unsigned N = DEF_NUM_PROCS
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic                 ptr_vld_i,
    output logic [N-1:0]         gnt_c,
    output logic [$clog2(N)-1:0] idx_c
);

    localparam int unsigned IW = $clog2(N);

    // First requester at or after the start position wins
    always_comb begin
        int unsigned cand;
        logic        found;
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr_vld_i ? ((32'(ptr_i) + 32'd1 + i) % N) : i;
            if (!found && req_i[IW'(cand)]) begin
                found = 1'b1;
                idx_c = IW'(cand);
            end
        end
        if (found) begin
            gnt_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoopy-bus arbiter and broadcast mux. Grants one cache at a time with
// round-robin priority, holds the grant until the owner's done pulse or a
// watchdog expiry, and broadcasts the owner's message/address/flush.
// Optional SNOOP_FLUSH_CHECK_EN: sticky flush_err_o on non-owner flush,
// plus grant/flush assertions.
module snoop_bus_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int unsigned NUM_PROCS = DEF_NUM_PROCS,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned MSG_W     = DEF_MSG_W,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PROCS-1:0]           req_i,
    input  logic [NUM_PROCS-1:0]           done_i,
    input  logic [NUM_PROCS*MSG_W-1:0]     msg_i,
    input  logic [NUM_PROCS*ADDR_SIZE-1:0] addr_i,
    input  logic [NUM_PROCS-1:0]           flush_i,
    output logic [NUM_PROCS-1:0]           gnt_o,
    output logic                           bus_valid_o,
    output logic [$clog2(NUM_PROCS)-1:0]   bus_owner_o,
    output logic [MSG_W-1:0]               bus_msg_o,
    output logic [ADDR_SIZE-1:0]           bus_addr_o,
    output logic                           flush_o,
    output logic                           timeout_o,
    output logic                           flush_err_o
);

    localparam int unsigned OW      = $clog2(NUM_PROCS);
    localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    bus_state_e           state_q, state_d;
    logic [NUM_PROCS-1:0] gnt_q, gnt_d;
    logic                 valid_q, valid_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        ptr_q, ptr_d;
    logic                 ptr_vld_q, ptr_vld_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 flush_err_q, flush_err_d;

    logic [NUM_PROCS-1:0] arb_gnt;
    logic [OW-1:0]        arb_idx;
    logic                 owner_done;

    rr_arbiter #(
        .N (NUM_PROCS)
    ) u_rr_arbiter (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .ptr_vld_i (ptr_vld_q),
        .gnt_c     (arb_gnt),
        .idx_c     (arb_idx)
    );

    // gnt_q is the owner's one-hot mask while BUSY, so it filters done_i
    assign owner_done = |(done_i & gnt_q);

    // Next-state, grant, pointer and watchdog logic
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        valid_d    = valid_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        ptr_vld_d  = ptr_vld_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d    = BUSY;
                    gnt_d      = arb_gnt;
                    valid_d    = 1'b1;
                    owner_d    = arb_idx;
                    ptr_d      = arb_idx;
                    ptr_vld_d  = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            BUSY: begin
                if (owner_done) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end else if (TIMEOUT != 0 && hold_cnt_q == CNT_W'(TO_LAST)) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Sticky error when a non-owner drives flush during a grant
    always_comb begin
`ifdef SNOOP_FLUSH_CHECK_EN
        flush_err_d = flush_err_q | (valid_q & |(flush_i & ~gnt_q));
`else
        flush_err_d = 1'b0;
`endif
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            valid_q     <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= '0;
            ptr_vld_q   <= 1'b0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            flush_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            valid_q     <= valid_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            ptr_vld_q   <= ptr_vld_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
            flush_err_q <= flush_err_d;
        end
    end

    // Broadcast mux: owner's payload while valid, zero otherwise
    always_comb begin
        bus_msg_o  = MSG_W'(BUS_NONE);
        bus_addr_o = '0;
        flush_o    = 1'b0;
        for (int unsigned k = 0; k < NUM_PROCS; k++) begin
            if (valid_q && owner_q == OW'(k)) begin
                bus_msg_o  = msg_i[k*MSG_W +: MSG_W];
                bus_addr_o = addr_i[k*ADDR_SIZE +: ADDR_SIZE];
                flush_o    = flush_i[k];
            end
        end
    end

    assign gnt_o       = gnt_q;
    assign bus_valid_o = valid_q;
    assign bus_owner_o = owner_q;
    assign timeout_o   = timeout_q;
    assign flush_err_o = flush_err_q;

`ifdef SNOOP_FLUSH_CHECK_EN
    // Grant must stay one-hot-or-zero; non-owners must not flush
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($onehot0(gnt_q))
                else $error("snoop_bus_arbiter: grant not one-hot");
            assert (!(valid_q && |(flush_i & ~gnt_q)))
                else $warning("snoop_bus_arbiter: non-owner flush during grant");
        end
    end
`endif

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
Parametrised arbiter and broadcast mux for the MSI snoopy bus shared by NUM_PROCS caches. It grants the bus to one requester using true round-robin priority, starting after the last owner. It holds the grant across a multi-cycle transaction until the owner releases it or a watchdog expires. While granted, it broadcasts the owner's message, address and flush to every cache for snooping.

Parameters:
NUM_PROCS, 4, number of cache ports (>=2)
ADDR_SIZE, 2, width of the snooped line address
MSG_W, 2, width of the bus message
TIMEOUT, 15, max cycles a grant is held before forced release; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
req_i  in  NUM_PROCS  per-cache bus request, level, held until granted
done_i  in  NUM_PROCS  per-cache transaction-complete pulse; only the owner's bit is honoured
msg_i  in  NUM_PROCS*MSG_W  per-cache message, flattened, cache k at [k*MSG_W +: MSG_W]
addr_i  in  NUM_PROCS*ADDR_SIZE  per-cache address, flattened the same way
flush_i  in  NUM_PROCS  per-cache flush indication
gnt_o  out  NUM_PROCS  one-hot grant, registered
bus_valid_o  out  1  bus carries a valid transaction
bus_owner_o  out  $clog2(NUM_PROCS)  index of current owner
bus_msg_o  out  MSG_W  broadcast message
bus_addr_o  out  ADDR_SIZE  broadcast address
flush_o  out  1  broadcast flush
timeout_o  out  1  one-cycle pulse on watchdog release
flush_err_o  out  1  sticky: a non-owner asserted flush during a grant

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, gnt_o=0, bus_valid_o=0, bus_owner_o=0, bus_msg_o=0, bus_addr_o=0, flush_o=0, timeout_o=0, flush_err_o=0, rr pointer=0, hold counter=0.
- FSM states:
  - IDLE: if |req_i, select the winner and go to BUSY. The registered gnt_o and bus_owner_o are valid the next cycle, so grant latency is 1 cycle from request. Otherwise stay in IDLE.
  - BUSY: bus_valid_o=1. On done_i[owner] or watchdog expiry, go to RELEASE.
  - RELEASE: one cycle with gnt_o=0 and bus_valid_o=0, then IDLE. This guarantees at least one idle cycle between transactions.
- Round-robin: the search starts at (last_owner+1) mod NUM_PROCS and wraps. The pointer updates to the winner's index on every grant. With all bits of req_i held high, grant order is 0,1,2,3,0,...
- Requests arriving in BUSY or RELEASE are not lost. Requesters keep req_i high and are arbitrated at the next IDLE.
- Mux: bus_msg_o, bus_addr_o and flush_o are combinational selections of the owner's inputs while bus_valid_o=1, and 0 otherwise. A non-owner's done_i is ignored.
- Watchdog: the hold counter clears on entry to BUSY and increments each BUSY cycle. On reaching TIMEOUT, it forces RELEASE and pulses timeout_o in the RELEASE cycle. If done_i[owner] arrives in the same cycle as expiry, it is a normal release and timeout_o stays 0. TIMEOUT=0: no watchdog, and timeout_o is tied 0.
- Reset mid-transaction: immediate return to reset values. The pointer returns to 0, so priority restarts at cache 0.

Optional Feature:
Macro SNOOP_FLUSH_CHECK_EN.
- Defined: flush_err_o is set whenever bus_valid_o=1 and any flush_i bit other than the owner's is 1. It stays set until reset. Immediate assertions also check that gnt_o is one-hot-or-zero and that flush_i is 0 for non-owners.
- Undefined: flush_err_o is tied 0 and no assertions are compiled.

Decomposition:
- Package snoop_bus_pkg holds:
  - Message encodings BUS_NONE=0, BUS_RD=1, BUS_RDX=2, BUS_UPGR=3.
  - FSM state enum IDLE/BUSY/RELEASE.
  - Default widths.
- Sub-module rr_arbiter: combinational; takes req and pointer, returns one-hot grant and winner index. It is instantiated once; the parent owns all state.

Test Plan:
- Reset release, no requests: all outputs stay 0 for 10 cycles.
- req_i=4'b0100, done_i[2] 3 cycles after grant: gnt_o=4'b0100 one cycle after the request; bus_owner_o=2; bus_msg_o and bus_addr_o follow cache 2; one RELEASE cycle; back to IDLE.
- req_i=4'b1111 held, each owner pulses done_i after 1 cycle: grant sequence 0,1,2,3,0. Never two grants without an intervening RELEASE.
- TIMEOUT=15, owner 1 never pulses done: forced release after 15 BUSY cycles; timeout_o=1 for exactly one cycle; next grant goes to the next requester after 1.
- Owner 0 granted, flush_i=4'b0010 during BUSY, SNOOP_FLUSH_CHECK_EN defined: flush_err_o=1 and sticky, flush_o=0. Then assert rst_i mid-BUSY: all outputs return to 0 asynchronously.
